// File: rtl/rv32_core_pkg.sv
// Shared RV32 core definitions: fetch-controller state encoding, NOP word and default vectors.
package rv32_core_pkg;

  typedef enum logic [2:0] {
    ST_RESET = 3'd0,
    ST_FETCH = 3'd1,
    ST_EXEC  = 3'd2,
    ST_TRAP  = 3'd3,
    ST_HALT  = 3'd4
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;
  localparam logic [31:0] DEFAULT_TRAP_VEC = 32'h0000_0100;

  // Only the two low target bits decide word alignment.
  function automatic logic is_misaligned(input logic [1:0] target_lsbs);
    return target_lsbs != 2'b00;
  endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Fetch/execute handshake bundle between pc_fetch_ctrl (master) and imem/execute side (slave).
interface pc_fetch_ctrl_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instr;
  logic        instr_valid;
  logic [31:0] pc_current;
  logic [31:0] pc_next;
  logic        exec_done;
  logic        stall;
  logic        halt_req;
  logic        trap;
  logic [31:0] trap_epc;
  logic [31:0] trap_tval;
  logic        halted;
  logic [31:0] retire_cnt;

  modport master (
    output imem_req, imem_addr, instr, instr_valid, pc_current,
           trap, trap_epc, trap_tval, halted, retire_cnt,
    input  imem_ack, imem_rdata, pc_next, exec_done, stall, halt_req
  );

  modport slave (
    input  imem_req, imem_addr, instr, instr_valid, pc_current,
           trap, trap_epc, trap_tval, halted, retire_cnt,
    output imem_ack, imem_rdata, pc_next, exec_done, stall, halt_req
  );

endinterface

// File: rtl/retire_counter.sv
// 32-bit enabled wrap-around counter of retired instructions, async active-low clear.
module retire_counter (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en_i,
  output logic [31:0] cnt_o
);

  logic [31:0] cnt_q;
  logic [31:0] cnt_d;

  // Modulo-2^32 wrap falls out of the fixed-width add.
  always_comb begin
    cnt_d = cnt_q;
    if (en_i) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= 32'd0;
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/pc_fetch_ctrl.sv
// RV32I program-counter sequencer: owns the PC, runs the imem fetch handshake,
// commits execute targets, traps misaligned targets and halts on request.
//   state    | meaning
//   ST_RESET | held in reset, leaves to FETCH on first edge after release
//   ST_FETCH | imem_req high at pc_current, wait for imem_ack
//   ST_EXEC  | instr_valid high, wait for exec_done with stall low
//   ST_TRAP  | one-cycle trap pulse, PC already at TRAP_VEC
//   ST_HALT  | sticky stop, only reset exits
module pc_fetch_ctrl
  import rv32_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC,
  parameter logic [31:0] TRAP_VEC = DEFAULT_TRAP_VEC
) (
  input logic             clk,
  input logic             rst_n,
  pc_fetch_ctrl_if.master bus
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  epc_q, epc_d;
  logic [31:0]  tval_q, tval_d;
  logic         retire_en;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_RESET;
      pc_q    <= RESET_PC;
      instr_q <= NOP_INSTR;
      epc_q   <= 32'd0;
      tval_q  <= 32'd0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      instr_q <= instr_d;
      epc_q   <= epc_d;
      tval_q  <= tval_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    epc_d     = epc_q;
    tval_d    = tval_q;
    retire_en = 1'b0;
    case (state_q)
      ST_RESET: state_d = ST_FETCH;
      ST_FETCH: begin
        if (bus.imem_ack) begin
          instr_d = bus.imem_rdata;
          state_d = ST_EXEC;
        end
      end
      ST_EXEC: begin
        // Halt outranks the alignment check, so ECALL with a junk target never traps.
        if (bus.exec_done && !bus.stall) begin
          if (bus.halt_req) begin
            retire_en = 1'b1;
            state_d   = ST_HALT;
          end else if (is_misaligned(bus.pc_next[1:0])) begin
            epc_d   = pc_q;
            tval_d  = bus.pc_next;
            pc_d    = TRAP_VEC;
            state_d = ST_TRAP;
          end else begin
            pc_d      = bus.pc_next;
            retire_en = 1'b1;
            state_d   = ST_FETCH;
          end
        end
      end
      ST_TRAP: state_d = ST_FETCH;
      ST_HALT: state_d = ST_HALT;
      default: state_d = ST_RESET;
    endcase
  end

  retire_counter u_retire (
    .clk   (clk),
    .rst_n (rst_n),
    .en_i  (retire_en),
    .cnt_o (bus.retire_cnt)
  );

  assign bus.imem_req    = (state_q == ST_FETCH);
  assign bus.imem_addr   = pc_q;
  assign bus.instr       = instr_q;
  assign bus.instr_valid = (state_q == ST_EXEC);
  assign bus.pc_current  = pc_q;
  assign bus.trap        = (state_q == ST_TRAP);
  assign bus.trap_epc    = epc_q;
  assign bus.trap_tval   = tval_q;
  assign bus.halted      = (state_q == ST_HALT);

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: hand-computed PC, instr, trap and retire expectations.
module tb_pc_fetch_ctrl;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  pc_fetch_ctrl_if bus_if ();

  pc_fetch_ctrl dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_vals(input string tag);
    check_val({tag, "_req"},    32'(bus_if.imem_req),    32'd0);
    check_val({tag, "_valid"},  32'(bus_if.instr_valid), 32'd0);
    check_val({tag, "_trap"},   32'(bus_if.trap),        32'd0);
    check_val({tag, "_halted"}, 32'(bus_if.halted),      32'd0);
    check_val({tag, "_pc"},     bus_if.pc_current,       32'h0000_0000);
    check_val({tag, "_instr"},  bus_if.instr,            32'h0000_0013);
    check_val({tag, "_epc"},    bus_if.trap_epc,         32'd0);
    check_val({tag, "_tval"},   bus_if.trap_tval,        32'd0);
    check_val({tag, "_retire"}, bus_if.retire_cnt,       32'd0);
  endtask

  initial begin
    n_checks = 0;
    n_fails  = 0;
    rst_n = 1'b1;
    bus_if.imem_ack   = 1'b0;
    bus_if.imem_rdata = 32'd0;
    bus_if.pc_next    = 32'd0;
    bus_if.exec_done  = 1'b0;
    bus_if.stall      = 1'b0;
    bus_if.halt_req   = 1'b0;

    #2 rst_n = 1'b0;
    #1 check_reset_vals("rst");
    tick();
    tick();
    check_val("rst_hold_req", 32'(bus_if.imem_req), 32'd0);

    // Straight-line: ack and exec_done always high, targets +4.
    bus_if.imem_ack  = 1'b1;
    bus_if.exec_done = 1'b1;
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      check_val("sl_req",      32'(bus_if.imem_req),    32'd1);
      check_val("sl_addr",     bus_if.imem_addr,        32'(4 * i));
      check_val("sl_valid_lo", 32'(bus_if.instr_valid), 32'd0);
      bus_if.imem_rdata = 32'h0000_1000 + 32'(i);
      bus_if.pc_next    = 32'(4 * (i + 1));
      tick();
      check_val("sl_valid_hi", 32'(bus_if.instr_valid), 32'd1);
      check_val("sl_instr",    bus_if.instr,            32'h0000_1000 + 32'(i));
      tick();
    end
    check_val("sl_retire", bus_if.retire_cnt, 32'd3);
    check_val("sl_addr3",  bus_if.imem_addr,  32'd12);

    // Fetch wait at 0x100.
    bus_if.imem_rdata = 32'h0000_2000;
    bus_if.pc_next    = 32'h0000_0100;
    tick();
    bus_if.imem_ack = 1'b0;
    tick();
    for (int i = 0; i < 5; i++) begin
      check_val("fw_req",   32'(bus_if.imem_req), 32'd1);
      check_val("fw_addr",  bus_if.imem_addr,     32'h0000_0100);
      check_val("fw_instr", bus_if.instr,         32'h0000_2000);
      tick();
    end
    check_val("fw_req_end", 32'(bus_if.imem_req), 32'd1);
    bus_if.imem_ack   = 1'b1;
    bus_if.imem_rdata = 32'hDEAD_0013;
    tick();
    check_val("fw_instr_ack", bus_if.instr,            32'hDEAD_0013);
    check_val("fw_valid",     32'(bus_if.instr_valid), 32'd1);

    // Stall in EXEC at 0x200.
    bus_if.pc_next = 32'h0000_0200;
    tick();
    check_val("st_retire5", bus_if.retire_cnt, 32'd5);
    bus_if.imem_rdata = 32'h0000_3000;
    tick();
    bus_if.stall   = 1'b1;
    bus_if.pc_next = 32'h0000_0210;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_val("st_pc",    bus_if.pc_current,       32'h0000_0200);
      check_val("st_valid", 32'(bus_if.instr_valid), 32'd1);
      check_val("st_req",   32'(bus_if.imem_req),    32'd0);
    end
    bus_if.stall = 1'b0;
    tick();
    check_val("st_addr",   bus_if.imem_addr,     32'h0000_0210);
    check_val("st_req_hi", 32'(bus_if.imem_req), 32'd1);
    check_val("st_retire", bus_if.retire_cnt,    32'd6);

    // Misaligned target from 0x300.
    tick();
    bus_if.pc_next = 32'h0000_0300;
    tick();
    tick();
    bus_if.pc_next = 32'h0000_1006;
    check_val("tr_pre", 32'(bus_if.trap), 32'd0);
    tick();
    check_val("tr_pulse",  32'(bus_if.trap),     32'd1);
    check_val("tr_epc",    bus_if.trap_epc,      32'h0000_0300);
    check_val("tr_tval",   bus_if.trap_tval,     32'h0000_1006);
    check_val("tr_pc",     bus_if.pc_current,    32'h0000_0100);
    check_val("tr_retire", bus_if.retire_cnt,    32'd7);
    check_val("tr_req",    32'(bus_if.imem_req), 32'd0);
    tick();
    check_val("tr_post",   32'(bus_if.trap),     32'd0);
    check_val("tr_fetch",  bus_if.imem_addr,     32'h0000_0100);
    check_val("tr_req_hi", 32'(bus_if.imem_req), 32'd1);

    // Reset while a fetch is pending, with ack arriving under reset.
    bus_if.imem_ack = 1'b0;
    tick();
    check_val("mr_pending", 32'(bus_if.imem_req), 32'd1);
    bus_if.imem_ack = 1'b1;
    rst_n = 1'b0;
    #1 check_reset_vals("mr");
    tick();
    check_val("mr_hold_req",   32'(bus_if.imem_req), 32'd0);
    check_val("mr_hold_instr", bus_if.instr,         32'h0000_0013);
    rst_n = 1'b1;
    tick();
    check_val("mr_addr", bus_if.imem_addr,  32'h0000_0000);

    // Counter wrap from preloaded all-ones.
    force dut.u_retire.cnt_q = 32'hFFFF_FFFF;
    #1 release dut.u_retire.cnt_q;
    #1 check_val("wr_preload", bus_if.retire_cnt, 32'hFFFF_FFFF);
    bus_if.imem_rdata = 32'h0000_4000;
    bus_if.pc_next    = 32'h0000_0004;
    tick();
    tick();
    check_val("wr_wrap", bus_if.retire_cnt, 32'd0);
    check_val("wr_addr", bus_if.imem_addr,  32'h0000_0004);

    // Halt together with a misaligned target: halt wins, no trap.
    tick();
    bus_if.halt_req = 1'b1;
    bus_if.pc_next  = 32'h0000_1002;
    tick();
    check_val("ht_halted", 32'(bus_if.halted),   32'd1);
    check_val("ht_trap",   32'(bus_if.trap),     32'd0);
    check_val("ht_req",    32'(bus_if.imem_req), 32'd0);
    check_val("ht_retire", bus_if.retire_cnt,    32'd1);
    check_val("ht_pc",     bus_if.pc_current,    32'h0000_0004);
    bus_if.halt_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick();
      check_val("ht_stick_req",  32'(bus_if.imem_req), 32'd0);
      check_val("ht_stick_trap", 32'(bus_if.trap),     32'd0);
      check_val("ht_stick_halt", 32'(bus_if.halted),   32'd1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/pc_fetch_ctrl.md
# pc_fetch_ctrl

Sequencing controller for the RV32I program counter. It owns the architectural PC register and runs the fetch/execute handshake with instruction memory. It accepts the PC target computed by `pc_next_logic` when execute completes, and commits it. It traps misaligned targets to a fixed vector, halts on request and counts retired instructions. It sits between the instruction-memory port and the execute datapath, replacing the free-running PC register used by the single-cycle core.

## Interface
Parameters:
- `RESET_PC`, 32'h0000_0000: PC loaded on reset.
- `TRAP_VEC`, 32'h0000_0100: PC loaded on a misaligned-target trap; must be word aligned.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `imem_req`  out  1  fetch request, held until acknowledged.
- `imem_addr`  out  32  fetch address; equals `pc_current` while `imem_req`=1.
- `imem_ack`  in  1  fetch complete; `imem_rdata` is valid in the same cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  latched instruction presented to decode/execute.
- `instr_valid`  out  1  high for every cycle in EXEC.
- `pc_current`  out  32  architectural PC, which drives `pc_next_logic.pc_current`.
- `pc_next`  in  32  target from `pc_next_logic`, sampled only on commit.
- `exec_done`  in  1  execute has finished and `pc_next` is stable.
- `stall`  in  1  blocks commit while high.
- `halt_req`  in  1  ECALL/EBREAK; sampled on commit.
- `trap`  out  1  one-cycle pulse when a misaligned-target trap is taken.
- `trap_epc`  out  32  PC of the instruction that produced the bad target.
- `trap_tval`  out  32  the offending target.
- `halted`  out  1  high while in HALT.
- `retire_cnt`  out  32  count of committed instructions.

## Operation
- States: RESET, FETCH, EXEC, TRAP, HALT. Encoding is 3-bit.
- **RESET:** entered asynchronously while `rst_n`=0. Leaves to FETCH on the first rising edge after deassertion.
- **FETCH:** `imem_req`=1 and `imem_addr`=`pc_current`.
  - On `imem_ack`: `instr`<=`imem_rdata`, then go to EXEC.
  - Without `imem_ack`: stay in FETCH. There is no timeout.
- **EXEC:** `instr_valid`=1. A commit occurs when `exec_done`=1 and `stall`=0. Commit priority is:
  1. `halt_req`=1: `retire_cnt`+1, `pc_current` is unchanged, go to HALT.
  2. `pc_next[1:0]`≠0: record `trap_epc`<=`pc_current` and `trap_tval`<=`pc_next`. Set `pc_current`<=`TRAP_VEC`, go to TRAP. `retire_cnt` does not increment.
  3. Otherwise: `pc_current`<=`pc_next`, `retire_cnt`+1, go to FETCH.
- **TRAP:** `trap`=1 for exactly one cycle, then go to FETCH.
- **HALT:** sticky; only `rst_n` exits. `halted`=1 and `imem_req`=0.
- **Stall:** `stall`=1 in EXEC holds all state and outputs. `stall` is ignored in every other state.
- **Arithmetic:**
  - `retire_cnt` is a 32-bit modulo counter; 32'hFFFF_FFFF+1 wraps to 0.
  - All PC values are 32-bit. No arithmetic is done here; targets come from `pc_next_logic`.

## Timing
- **Reset values:**
  - `pc_current`=`RESET_PC`
  - `instr`=32'h0000_0013 (NOP)
  - `imem_req`=0, `instr_valid`=0, `trap`=0, `halted`=0
  - `trap_epc`=0, `trap_tval`=0, `retire_cnt`=0
- **Reset mid-operation:** asserting `rst_n`=0 in any state (including a pending FETCH) immediately forces all reset values. Any outstanding `imem_ack` is ignored.
- **Outputs:** all outputs are registered, or decoded from state only; there is no combinational path from inputs to outputs.
- **Minimum instruction latency:** 1 cycle in FETCH (ack in the first cycle) plus 1 cycle in EXEC (`exec_done` in the first cycle), so the best case is 2 cycles per instruction.
- **Trap latency:** commit edge, then 1 cycle in TRAP, then FETCH of `TRAP_VEC`.
- **Ignored inputs:**
  - `exec_done`, `halt_req` and `pc_next` outside EXEC.
  - `imem_ack` outside FETCH.
- **Simultaneous events:** `halt_req` together with a misaligned `pc_next` results in HALT, with no trap.

## Structure
- Shared package `rv32_core_pkg` holds:
  - the state encoding constants `ST_RESET`, `ST_FETCH`, `ST_EXEC`, `ST_TRAP`, `ST_HALT`
  - `NOP_INSTR`=32'h0000_0013
  - the default `RESET_PC` and `TRAP_VEC` values.
- One sub-module is natural: `retire_counter`, a 32-bit enabled wrap-around counter with async active-low clear.
- `pc_next_logic` stays external; the top level connects it.

## Test plan
- **Reset then straight-line fetch:** release `rst_n` with `imem_ack` tied to 1, `exec_done`=1 and `pc_next`=`pc_current`+4.
  - `imem_addr` sequence is 0, 4, 8, alternating FETCH/EXEC.
  - `retire_cnt`=3 after the third commit.
- **Fetch wait:** hold `imem_ack`=0 for 5 cycles at PC 0x100.
  - `imem_req` stays 1 and `imem_addr` stays 0x100.
  - `instr` is updated only on the ack cycle.
- **Stall:** in EXEC, assert `stall`=1 for 3 cycles with `exec_done`=1 and `pc_next`=0x210.
  - PC stays 0x200 and `instr_valid` stays 1.
  - The commit to 0x210 occurs on the first cycle with `stall`=0.
- **Misaligned target:** at PC 0x300, present `pc_next`=0x0000_1006 on commit.
  - `trap` pulses once; `trap_epc`=0x300 and `trap_tval`=0x1006.
  - Next fetch is at 0x100; `retire_cnt` is unchanged.
- **Halt:** `halt_req`=1 on commit, with `pc_next` misaligned at the same time.
  - `halted`=1 with no trap pulse; `imem_req` stays 0 indefinitely.
  - `retire_cnt` increments by 1.
- **Reset mid-fetch, and counter wrap:**
  - Drop `rst_n` during FETCH: all outputs take their reset values asynchronously.
  - Preload the counter to 32'hFFFF_FFFF via the bench force; one commit wraps it to 0.
